// File: rtl/pipe_stage_buf_if.sv
// Handshake and payload bundle between a pipeline stage buffer and its neighbours.
// The master side drives the upstream payload and downstream/flush control; the slave is the buffer.
interface pipe_stage_buf_if #(
    parameter int BUS_W = 64
);
    logic             in_valid;
    logic [BUS_W-1:0] in_bus;
    logic             this_allowin;
    logic             ready_go;
    logic             next_allowin;
    logic             out_valid;
    logic [BUS_W-1:0] out_bus;
    logic             flush;
    logic             stage_valid;
    logic [2:0]       occupancy;

    modport master (
        output in_valid, in_bus, ready_go, next_allowin, flush,
        input  this_allowin, out_valid, out_bus, stage_valid, occupancy
    );

    modport slave (
        input  in_valid, in_bus, ready_go, next_allowin, flush,
        output this_allowin, out_valid, out_bus, stage_valid, occupancy
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: a small circular FIFO (1..4 entries) with valid/allowin handshake,
// head-only ready_go qualification and a flush that cancels everything held.
module pipe_stage_buf #(
    parameter int BUS_W = 64,
    parameter int DEPTH = 1
) (
    input logic           clk,
    input logic           reset,
    pipe_stage_buf_if.slave bus
);
    localparam logic [1:0] LAST = 2'(DEPTH - 1);
    localparam logic [2:0] CAP  = 3'(DEPTH);

    // Storage is always four entries so the 2-bit pointers index it cleanly; only DEPTH are used.
    logic [BUS_W-1:0] mem [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [2:0]       count;
    logic             held;
    logic             out_valid;
    logic             pop;
    logic             allowin;
    logic             push;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        held      = (count != 3'd0);
        out_valid = held && bus.ready_go && !bus.flush;
        pop       = out_valid && bus.next_allowin;
        allowin   = (count < CAP) || pop || bus.flush;
        push      = bus.in_valid && allowin && !bus.flush;
    end

    assign bus.stage_valid  = held;
    assign bus.out_valid    = out_valid;
    assign bus.this_allowin = allowin;
    assign bus.occupancy    = count;
    assign bus.out_bus      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 3'd0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Cancelled entries keep their stale data; only the bookkeeping is cleared.
            count  <= 3'd0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.in_bus;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter BUS_W, default 64, SHALL set the width in bits of the stage payload bus.
REQ-002 Parameter DEPTH, default 1, range 1..4, SHALL set the number of buffered entries; DEPTH=1 gives a plain single-register pipeline stage.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL mean the upstream stage presents a valid payload.
REQ-006 in_bus  in  BUS_W  SHALL carry the upstream payload.
REQ-007 this_allowin  out  1  SHALL mean this stage accepts a payload this cycle.
REQ-008 ready_go  in  1  SHALL mean the head entry has finished its work in this stage.
REQ-009 next_allowin  in  1  SHALL mean the downstream stage accepts a payload this cycle.
REQ-010 out_valid  out  1  SHALL mean the head payload is offered downstream.
REQ-011 out_bus  out  BUS_W  SHALL carry the head payload.
REQ-012 flush  in  1  SHALL discard all buffered entries (branch or exception cancel).
REQ-013 stage_valid  out  1  SHALL be high whenever at least one entry is held; used for hazard detection.
REQ-014 occupancy  out  3  SHALL report the number of held entries, 0..DEPTH.

Function
REQ-015 push SHALL be in_valid && this_allowin && !flush; pop SHALL be out_valid && next_allowin.
REQ-016 out_valid SHALL be stage_valid && ready_go && !flush, combinationally.
REQ-017 this_allowin SHALL be (occupancy < DEPTH) || pop || flush, combinationally.
REQ-018 A pushed payload SHALL be written at the tail and become visible at out_bus when it reaches the head, no earlier than the cycle after the push (latency 1 cycle minimum).
REQ-019 Entries SHALL leave in arrival order; out_bus SHALL equal the oldest held entry.
REQ-020 out_bus SHALL stay stable while out_valid is high and next_allowin is low.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged, including when full (occupancy = DEPTH).
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-023 Pop when empty and push when full without a pop SHALL NOT occur by construction; occupancy SHALL never exceed DEPTH or go below 0.
REQ-024 flush SHALL take priority over push and pop: on the next edge occupancy = 0 and both pointers = 0; a payload offered in the flush cycle is dropped.
REQ-025 ready_go SHALL qualify the head entry only; entries behind it wait regardless of ready_go.
REQ-026 With DEPTH=1 the block SHALL reduce to: stage_valid <= push ? 1 : (pop ? 0 : stage_valid); this_allowin = !stage_valid || (ready_go && next_allowin) || flush.

Reset
REQ-027 While reset is high at a rising edge, occupancy, both pointers, and all entry storage SHALL clear to 0.
REQ-028 After reset: stage_valid = 0, out_valid = 0, occupancy = 0, out_bus = 0, this_allowin = 1.
REQ-029 Reset SHALL override flush, push and pop in the same cycle; in-flight entries are lost.

Verification
REQ-030 DEPTH=1, ready_go=1, next_allowin=1, push 0xA then 0xB on consecutive cycles -> out_bus 0xA one cycle after push, then 0xB; occupancy never exceeds 1.
REQ-031 DEPTH=4, next_allowin=0, push 5 payloads 1..5 -> this_allowin drops after 4th; occupancy=4; out_bus=1 held stable; releasing next_allowin yields 1,2,3,4 in order.
REQ-032 DEPTH=3, full, push 0x7 and pop in same cycle -> occupancy stays 3, tail write wraps to index 0, 0x7 emerges after the two older entries.
REQ-033 DEPTH=4, occupancy=2, assert flush with in_valid=1 -> next cycle occupancy=0, stage_valid=0, out_valid=0 during the flush cycle; offered payload never appears at out_bus.
REQ-034 ready_go=0 with occupancy=1, next_allowin=1 -> out_valid=0, entry held; ready_go=1 next cycle -> out_valid=1, pop.
REQ-035 Assert reset with occupancy=3 -> next cycle all outputs at REQ-028 values; first subsequent push appears unchanged at out_bus.
